// File: rtl/cfg_chain_loader.sv
// cfg_chain_loader
//   Master side of the fabric configuration shift chain. Accepts the
//   bitstream as bytes on a valid/ready handshake and shifts it MSB-first
//   into the chain head as exactly CHAIN_LEN prog_clk pulses. Unused
//   low-order bits of the last byte are dropped without pulses.
//
//   Optional feature (macro CFG_LOADER_VERIFY_EN): a CRC-16-CCITT is kept
//   over every loaded bit. A second pass of CHAIN_LEN pulses then
//   recirculates prog_out into prog_in, which leaves the chain contents
//   unchanged, and a second CRC is kept over prog_out. Differing CRCs set
//   error. Without the macro there are no verify states and error is 0.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   start      one-cycle pulse, begins a load when idle
//   cfg_data   bitstream byte
//   cfg_valid  cfg_data valid
//   cfg_ready  byte accepted this cycle (FETCH only)
//   prog_clk   configuration shift clock
//   prog_en    chain shift enable
//   prog_in    serial bit to the chain head
//   prog_out   serial bit from the chain tail
//   busy       load (or verify) in progress
//   done       sticky completion flag
//   error      verify mismatch
//
// state     | meaning
// IDLE      | waiting for start
// FETCH     | cfg_ready high, waiting for the next byte
// SHIFT_LO  | prog_in driven, prog_clk low for CLK_DIV cycles
// SHIFT_HI  | prog_clk high for CLK_DIV cycles, chain samples on the rise
// VERIFY_LO | recirculation pass, prog_clk low (verify build)
// VERIFY_HI | recirculation pass, prog_clk high (verify build)
// CHECK     | compare load CRC against readback CRC (verify build)
// DONE      | drop prog_en and busy, raise done, back to IDLE
module cfg_chain_loader #(
   parameter int CHAIN_LEN = 80,
   parameter int CLK_DIV   = 2,
   parameter int CNT_W     = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] cfg_data,
   input  logic       cfg_valid,
   output logic       cfg_ready,
   output logic       prog_clk,
   output logic       prog_en,
   output logic       prog_in,
   input  logic       prog_out,
   output logic       busy,
   output logic       done,
   output logic       error
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_INIT = DIV_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);

`ifdef CFG_LOADER_VERIFY_EN
   typedef enum logic [2:0] {
      IDLE, FETCH, SHIFT_LO, SHIFT_HI, DONE, VERIFY_LO, VERIFY_HI, CHECK
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE, FETCH, SHIFT_LO, SHIFT_HI, DONE
   } state_t;
`endif

   state_t           state;
   logic [7:0]       shift_reg;
   logic [2:0]       bit_idx;
   logic [2:0]       nxt_idx;
   logic [CNT_W-1:0] bit_cnt;
   logic [DIV_W-1:0] div_cnt;

   assign nxt_idx = bit_idx - 3'd1;

`ifdef CFG_LOADER_VERIFY_EN
   logic [15:0] crc_in;
   logic [15:0] crc_out;
   logic        error_r;

   // CRC-16-CCITT, one bit per step, polynomial 0x1021
   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
      return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
   endfunction

   assign error = error_r;
`else
   wire unused_prog_out = prog_out;
   assign error = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         shift_reg <= '0;
         bit_idx   <= '0;
         bit_cnt   <= '0;
         div_cnt   <= '0;
         cfg_ready <= 1'b0;
         prog_clk  <= 1'b0;
         prog_en   <= 1'b0;
         prog_in   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
`ifdef CFG_LOADER_VERIFY_EN
         crc_in    <= 16'hFFFF;
         crc_out   <= 16'hFFFF;
         error_r   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state     <= FETCH;
                  cfg_ready <= 1'b1;
                  busy      <= 1'b1;
                  prog_en   <= 1'b1;
                  done      <= 1'b0;
                  bit_cnt   <= '0;
`ifdef CFG_LOADER_VERIFY_EN
                  error_r   <= 1'b0;
                  crc_in    <= 16'hFFFF;
                  crc_out   <= 16'hFFFF;
`endif
               end
            end
            FETCH: begin
               if (cfg_valid) begin
                  shift_reg <= cfg_data;
                  bit_idx   <= 3'd7;
                  prog_in   <= cfg_data[7];
                  cfg_ready <= 1'b0;
                  div_cnt   <= DIV_INIT;
                  state     <= SHIFT_LO;
`ifdef CFG_LOADER_VERIFY_EN
                  crc_in    <= crc_step(crc_in, cfg_data[7]);
`endif
               end
            end
            SHIFT_LO: begin
               if (div_cnt == '0) begin
                  prog_clk <= 1'b1;
                  div_cnt  <= DIV_INIT;
                  state    <= SHIFT_HI;
               end else begin
                  div_cnt <= div_cnt - 1'b1;
               end
            end
            SHIFT_HI: begin
               if (div_cnt == '0) begin
                  prog_clk <= 1'b0;
                  div_cnt  <= DIV_INIT;
                  if (bit_cnt == LAST_BIT) begin
`ifdef CFG_LOADER_VERIFY_EN
                     // bit_cnt is reused to count the recirculation pulses
                     bit_cnt <= '0;
                     prog_in <= prog_out;
                     crc_out <= crc_step(crc_out, prog_out);
                     state   <= VERIFY_LO;
`else
                     bit_cnt <= bit_cnt + 1'b1;
                     state   <= DONE;
`endif
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                     if (bit_idx == 3'd0) begin
                        cfg_ready <= 1'b1;
                        state     <= FETCH;
                     end else begin
                        bit_idx <= nxt_idx;
                        prog_in <= shift_reg[nxt_idx];
                        state   <= SHIFT_LO;
`ifdef CFG_LOADER_VERIFY_EN
                        crc_in  <= crc_step(crc_in, shift_reg[nxt_idx]);
`endif
                     end
                  end
               end else begin
                  div_cnt <= div_cnt - 1'b1;
               end
            end
`ifdef CFG_LOADER_VERIFY_EN
            VERIFY_LO: begin
               if (div_cnt == '0) begin
                  prog_clk <= 1'b1;
                  div_cnt  <= DIV_INIT;
                  state    <= VERIFY_HI;
               end else begin
                  div_cnt <= div_cnt - 1'b1;
               end
            end
            VERIFY_HI: begin
               if (div_cnt == '0) begin
                  prog_clk <= 1'b0;
                  div_cnt  <= DIV_INIT;
                  if (bit_cnt == LAST_BIT) begin
                     state <= CHECK;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                     prog_in <= prog_out;
                     crc_out <= crc_step(crc_out, prog_out);
                     state   <= VERIFY_LO;
                  end
               end else begin
                  div_cnt <= div_cnt - 1'b1;
               end
            end
            CHECK: begin
               error_r <= (crc_in != crc_out);
               state   <= DONE;
            end
`endif
            DONE: begin
               prog_en  <= 1'b0;
               prog_clk <= 1'b0;
               busy     <= 1'b0;
               done     <= 1'b1;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
